// File: rtl/lstm_seq_ctrl.sv
// Timestep sequencer for the LSTM cell: x stream in, recurrent h/c held, h stream out.
// Optional cell watchdog enabled by defining LSTM_SEQ_TIMEOUT_EN.
module lstm_seq_ctrl #(
    parameter int INPUT_SIZE     = 2,
    parameter int HIDDEN_SIZE    = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_SEQ_LEN    = 256,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int LEN_W         = $clog2(MAX_SEQ_LEN + 1),
    localparam int XW            = INPUT_SIZE * DATA_WIDTH,
    localparam int HW            = HIDDEN_SIZE * DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seq_start,
    input  logic [LEN_W-1:0] seq_len,
    output logic             seq_busy,
    output logic             seq_done,
    input  logic             x_valid,
    output logic             x_ready,
    input  logic [XW-1:0]    x_data,
    output logic             cell_start,
    input  logic             cell_done,
    output logic [XW-1:0]    cell_x,
    output logic [HW-1:0]    cell_h_prev,
    output logic [HW-1:0]    cell_c_prev,
    input  logic [HW-1:0]    cell_h,
    input  logic [HW-1:0]    cell_c,
    output logic             h_valid,
    input  logic             h_ready,
    output logic [HW-1:0]    h_data,
    output logic             h_last
`ifdef LSTM_SEQ_TIMEOUT_EN
    ,
    output logic             cell_timeout
`endif
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_X    = 3'd1;
    localparam logic [2:0] S_RUN       = 3'd2;
    localparam logic [2:0] S_WAIT_CELL = 3'd3;
    localparam logic [2:0] S_EMIT      = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_SEQ_LEN);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    logic [2:0]       state;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] step_cnt;
    logic [XW-1:0]    x_q;
    logic [HW-1:0]    h_st;
    logic [HW-1:0]    c_st;
    logic [HW-1:0]    h_out;
    logic             last_step;

    assign last_step = (step_cnt == len - LEN_ONE);

`ifdef LSTM_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LIM = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tcnt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            len      <= '0;
            step_cnt <= '0;
            x_q      <= '0;
            h_st     <= '0;
            c_st     <= '0;
            h_out    <= '0;
`ifdef LSTM_SEQ_TIMEOUT_EN
            tcnt         <= '0;
            cell_timeout <= 1'b0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (seq_start) begin
                        len      <= (seq_len > LEN_MAX) ? LEN_MAX : seq_len;
                        h_st     <= '0;
                        c_st     <= '0;
                        step_cnt <= '0;
`ifdef LSTM_SEQ_TIMEOUT_EN
                        cell_timeout <= 1'b0;
`endif
                        state    <= (seq_len == '0) ? S_DONE : S_WAIT_X;
                    end
                end
                S_WAIT_X: begin
                    if (x_valid) begin
                        x_q   <= x_data;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
`ifdef LSTM_SEQ_TIMEOUT_EN
                    tcnt  <= '0;
`endif
                    state <= S_WAIT_CELL;
                end
                S_WAIT_CELL: begin
                    if (cell_done) begin
                        h_st  <= cell_h;
                        h_out <= cell_h;
                        c_st  <= cell_c;
                        state <= S_EMIT;
                    end
`ifdef LSTM_SEQ_TIMEOUT_EN
                    else if (tcnt == T_LIM) begin
                        cell_timeout <= 1'b1;
                        state        <= S_DONE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
`endif
                end
                S_EMIT: begin
                    if (h_ready) begin
                        if (last_step) begin
                            state <= S_DONE;
                        end else begin
                            step_cnt <= step_cnt + LEN_ONE;
                            state    <= S_WAIT_X;
                        end
                    end
                end
                S_DONE: begin
                    step_cnt <= '0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Handshake and status outputs decode straight from state so reset clears them at once.
    assign seq_busy    = (state != S_IDLE);
    assign seq_done    = (state == S_DONE);
    assign x_ready     = (state == S_WAIT_X);
    assign cell_start  = (state == S_RUN);
    assign h_valid     = (state == S_EMIT);
    assign h_last      = h_valid && last_step;
    assign h_data      = h_out;
    assign cell_x      = x_q;
    assign cell_h_prev = h_st;
    assign cell_c_prev = c_st;

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// Scoreboard bench for lstm_seq_ctrl with a behavioural accumulating cell model.
module tb_lstm_seq_ctrl;

    localparam int IS   = 2;
    localparam int HS   = 2;
    localparam int DW   = 32;
    localparam int MAXL = 6;
    localparam int LW   = $clog2(MAXL + 1);
    localparam int XW   = IS * DW;
    localparam int HW   = HS * DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          seq_start;
    logic [LW-1:0] seq_len;
    logic          seq_busy;
    logic          seq_done;
    logic          x_valid;
    logic          x_ready;
    logic [XW-1:0] x_data;
    logic          cell_start;
    logic          cell_done;
    logic [XW-1:0] cell_x;
    logic [HW-1:0] cell_h_prev;
    logic [HW-1:0] cell_c_prev;
    logic [HW-1:0] cell_h;
    logic [HW-1:0] cell_c;
    logic          h_valid;
    logic          h_ready;
    logic [HW-1:0] h_data;
    logic          h_last;

    lstm_seq_ctrl #(
        .INPUT_SIZE (IS),
        .HIDDEN_SIZE(HS),
        .DATA_WIDTH (DW),
        .MAX_SEQ_LEN(MAXL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seq_start  (seq_start),
        .seq_len    (seq_len),
        .seq_busy   (seq_busy),
        .seq_done   (seq_done),
        .x_valid    (x_valid),
        .x_ready    (x_ready),
        .x_data     (x_data),
        .cell_start (cell_start),
        .cell_done  (cell_done),
        .cell_x     (cell_x),
        .cell_h_prev(cell_h_prev),
        .cell_c_prev(cell_c_prev),
        .cell_h     (cell_h),
        .cell_c     (cell_c),
        .h_valid    (h_valid),
        .h_ready    (h_ready),
        .h_data     (h_data),
        .h_last     (h_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [HW-1:0] h;
        logic          last;
    } hexp_t;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [HW-1:0] hp;
    } pexp_t;

    hexp_t exp_h[$];
    pexp_t exp_p[$];

    int total = 0;
    int bad = 0;
    int done_seen = 0;
    int epoch = 0;
    int lat_fix = 0;
    bit hold_low = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [HW-1:0] vadd(input logic [HW-1:0] a, input logic [XW-1:0] b);
        logic [HW-1:0] r;
        for (int i = 0; i < HS; i++) r[i*DW +: DW] = a[i*DW +: DW] + b[i*DW +: DW];
        return r;
    endfunction

    // cell model: h = h_prev + x, c = h, done after a few cycles
    initial begin
        cell_done = 1'b0;
        cell_h = '0;
        cell_c = '0;
        forever begin
            @(negedge clk);
            if (rst_n && cell_start) begin
                logic [HW-1:0] hn;
                int ep;
                int lat;
                pexp_t e;
                if (exp_p.size() == 0) begin
                    chk("cell_start_unexpected", cell_start, 0);
                end else begin
                    e = exp_p.pop_front();
                    chk("cell_x", cell_x, e.x);
                    chk("cell_h_prev", cell_h_prev, e.hp);
                    chk("cell_c_prev", cell_c_prev, e.hp);
                end
                hn = vadd(cell_h_prev, cell_x);
                ep = epoch;
                lat = (lat_fix != 0) ? lat_fix : $urandom_range(1, 6);
                repeat (lat) @(posedge clk);
                #2;
                if (ep == epoch) begin
                    cell_done = 1'b1;
                    cell_h = hn;
                    cell_c = hn;
                    @(posedge clk);
                    #2;
                    cell_done = 1'b0;
                    cell_h = {$urandom, $urandom};
                    cell_c = {$urandom, $urandom};
                end
            end
        end
    end

    initial begin
        h_ready = 1'b0;
        forever begin
            @(posedge clk);
            #3;
            h_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // monitor: output checks against the scoreboard queue
    initial begin
        bit stalled;
        logic [HW:0] prev;
        stalled = 0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 0;
            end else begin
                if (stalled) begin
                    chk("h_hold_valid", h_valid, 1);
                    chk("h_hold_data", {h_last, h_data}, prev);
                end
                chk("xready_hvalid_excl", x_ready & h_valid, 0);
                if (h_valid && h_ready) begin
                    if (exp_h.size() == 0) begin
                        chk("h_unexpected", h_valid, 0);
                    end else begin
                        hexp_t e;
                        e = exp_h.pop_front();
                        chk("h_data", h_data, e.h);
                        chk("h_last", h_last, e.last);
                    end
                end
                stalled = h_valid && !h_ready;
                prev = {h_last, h_data};
                if (seq_done) done_seen++;
            end
        end
    end

    task automatic send_x(input logic [XW-1:0] x);
        int k;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #2;
        x_valid = 1'b1;
        x_data = x;
        k = 0;
        @(negedge clk);
        while (!x_ready && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("x_accept", x_ready, 1);
        @(posedge clk);
        #2;
        x_valid = 1'b0;
        x_data = {$urandom, $urandom};
    endtask

    task automatic pulse_start(input logic [LW-1:0] len);
        @(posedge clk);
        #2;
        seq_start = 1'b1;
        seq_len = len;
        @(posedge clk);
        #2;
        seq_start = 1'b0;
        seq_len = LW'($urandom);
    endtask

    task automatic run_seq(input int len, input bit fixed, input bit hold, input bit poke);
        int n;
        int k;
        int target;
        logic [HW-1:0] h;
        logic [XW-1:0] xs[$];
        n = (len > MAXL) ? MAXL : len;
        h = '0;
        for (int t = 0; t < n; t++) begin
            logic [XW-1:0] x;
            if (fixed) x = {DW'(2 * t + 2), DW'(2 * t + 1)};
            else x = {$urandom, $urandom};
            xs.push_back(x);
            exp_p.push_back('{x: x, hp: h});
            h = vadd(h, x);
            exp_h.push_back('{h: h, last: (t == n - 1)});
        end
        target = done_seen + 1;
        pulse_start(LW'(len));
        for (int t = 0; t < n; t++) begin
            send_x(xs[t]);
            if (t == 0 && poke) begin
                seq_start = 1'b1;
                seq_len = LW'(3);
                @(posedge clk);
                #2;
                seq_start = 1'b0;
            end
            if (t == 0 && hold) begin
                hold_low = 1;
                h_ready = 1'b0;
                k = 0;
                @(negedge clk);
                while (!h_valid && k < 200) begin
                    @(negedge clk);
                    k++;
                end
                for (int c = 0; c < 10; c++) begin
                    chk("hold_h_valid", h_valid, 1);
                    chk("hold_x_ready", x_ready, 0);
                    chk("hold_cell_start", cell_start, 0);
                    @(negedge clk);
                end
                hold_low = 0;
            end
        end
        k = 0;
        while (done_seen < target && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("seq_done_count", done_seen, target);
        chk("h_drained", exp_h.size(), 0);
        @(negedge clk);
        chk("idle_after_seq", seq_busy, 0);
    endtask

    initial begin
        int dc;
        int bc;
        int xc;
        int cc;
        rst_n = 1'b0;
        seq_start = 1'b0;
        seq_len = '0;
        x_valid = 1'b0;
        x_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", seq_busy, 0);
        chk("rst_done", seq_done, 0);
        chk("rst_x_ready", x_ready, 0);
        chk("rst_cell_start", cell_start, 0);
        chk("rst_h_valid", h_valid, 0);
        chk("rst_cell_x", cell_x, 0);
        chk("rst_h_prev", cell_h_prev, 0);
        chk("rst_h_data", h_data, 0);
        #1;
        rst_n = 1'b1;

        run_seq(3, 1, 0, 0);

        // zero-length sequence
        dc = 0;
        bc = 0;
        xc = 0;
        cc = 0;
        @(posedge clk);
        #2;
        seq_start = 1'b1;
        seq_len = '0;
        @(posedge clk);
        #2;
        seq_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            dc += int'(seq_done);
            bc += int'(seq_busy);
            xc += int'(x_ready);
            cc += int'(cell_start);
        end
        chk("len0_done_pulses", dc, 1);
        chk("len0_busy_cycles", bc, 1);
        chk("len0_x_ready", xc, 0);
        chk("len0_cell_start", cc, 0);

        run_seq(4, 0, 1, 0);
        run_seq(3, 0, 0, 1);
        run_seq(1, 0, 0, 0);
        run_seq(7, 0, 0, 0);
        for (int i = 0; i < 12; i++) run_seq($urandom_range(0, 7), 0, 0, 0);

        // reset while the cell is busy
        lat_fix = 6;
        exp_p.push_back('{x: {DW'(7), DW'(9)}, hp: '0});
        pulse_start(LW'(3));
        send_x({DW'(7), DW'(9)});
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", seq_busy, 0);
        chk("mid_rst_x_ready", x_ready, 0);
        chk("mid_rst_cell_start", cell_start, 0);
        chk("mid_rst_h_valid", h_valid, 0);
        chk("mid_rst_done", seq_done, 0);
        chk("mid_rst_cell_x", cell_x, 0);
        chk("mid_rst_c_prev", cell_c_prev, 0);
        epoch++;
        exp_h.delete();
        exp_p.delete();
        lat_fix = 0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        run_seq(2, 0, 0, 0);
        run_seq(2, 1, 0, 0);

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
